// File: rtl/encoder_pkg.sv
// Shared types and constants for the sentence-encoder pooling path.
//   pool_state_t : mean_pool_stage control states
//   LANE_W       : width of one Q16.16 stream word
//   FRAC_W       : fractional bits of a Q16.16 word
package encoder_pkg;

  localparam int unsigned LANE_W = 32;
  localparam int unsigned FRAC_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DIV   = 3'd2,
    OUT   = 3'd3,
    FIN   = 3'd4
  } pool_state_t;

endpackage

// File: rtl/seq_divider.sv
// Sequential restoring divider: signed numerator / unsigned non-zero denominator,
// quotient truncated toward zero. One load cycle, then NUM_W iteration cycles.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : load numer/denom and begin (ignored state is overwritten)
//   numer    : two's-complement dividend, NUM_W bits
//   denom    : unsigned divisor, DEN_W bits, must be non-zero
//   busy     : iteration in progress
//   done     : 1-cycle pulse, quot valid from this cycle until next start
//   quot     : two's-complement quotient, NUM_W bits
module seq_divider #(
  parameter int unsigned NUM_W = 39,
  parameter int unsigned DEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] numer,
  input  logic [DEN_W-1:0] denom,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quot
);

  localparam int unsigned CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] q_q;
  logic [DEN_W-1:0] rem_q;
  logic [DEN_W-1:0] den_q;
  logic             neg_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DEN_W:0]   trial_c;
  logic             fits_c;
  logic [DEN_W-1:0] rem_next_c;
  logic [NUM_W-1:0] q_next_c;

  // One restoring step on the magnitude; remainder always stays below den_q.
  always_comb begin
    trial_c    = {rem_q, q_q[NUM_W-1]};
    fits_c     = (trial_c >= {1'b0, den_q});
    rem_next_c = fits_c ? DEN_W'(trial_c - {1'b0, den_q}) : trial_c[DEN_W-1:0];
    q_next_c   = {q_q[NUM_W-2:0], fits_c};
  end

  // Load magnitude on start, iterate NUM_W times, re-apply sign at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      quot  <= '0;
      q_q   <= '0;
      rem_q <= '0;
      den_q <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        neg_q <= numer[NUM_W-1];
        q_q   <= numer[NUM_W-1] ? -numer : numer;
        rem_q <= '0;
        den_q <= denom;
        cnt_q <= CNT_W'(NUM_W);
      end else if (busy) begin
        q_q   <= q_next_c;
        rem_q <= rem_next_c;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          quot <= neg_q ? -q_next_c : q_next_c;
        end
      end
    end
  end

endmodule

// File: rtl/mean_pool_stage.sv
// Mean-pooling stage after the last transformer layer: sums token embeddings per
// dimension over sequence_length tokens, divides by the token count and streams
// out one pooled EMBEDDING_DIM vector, LANES Q16.16 words per beat.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a sequence (sampled only in IDLE)
//   sequence_length   : token count, 1..MAX_TOKENS, sampled with start
//   busy, done, err   : status; err is sticky until the next accepted start
//   in_valid/in_ready : input beat handshake; in_data lanes, in_last final beat
//   out_valid/out_ready : output beat handshake; out_data means, out_last on last row
module mean_pool_stage
  import encoder_pkg::*;
#(
  parameter int unsigned EMBEDDING_DIM = 384,
  parameter int unsigned MAX_TOKENS    = 128,
  parameter int unsigned BUS_WIDTH     = 512
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(MAX_TOKENS):0]  sequence_length,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BUS_WIDTH-1:0]         in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BUS_WIDTH-1:0]         out_data,
  output logic                         out_last
);

  localparam int unsigned LANES = BUS_WIDTH / LANE_W;
  localparam int unsigned ROWS  = EMBEDDING_DIM / LANES;
  localparam int unsigned ACC_W = LANE_W + $clog2(MAX_TOKENS);
  localparam int unsigned LEN_W = $clog2(MAX_TOKENS) + 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  pool_state_t          state_q, state_d;
  logic [LEN_W-1:0]     n_q, n_d;
  logic [LEN_W-1:0]     tok_cnt_q, tok_cnt_d;
  logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
  logic                 busy_d, done_d, err_d, in_ready_d;
  logic                 out_valid_d, out_last_d;
  logic [BUS_WIDTH-1:0] out_data_d;
  logic                 div_start_q, div_start_d;

  logic [ACC_W-1:0]     acc_q [ROWS][LANES];
  logic [ACC_W-1:0]     lane_ext_c [LANES];

  logic [LANES-1:0]     div_busy;
  logic [LANES-1:0]     div_done;
  logic [ACC_W-1:0]     div_quot [LANES];
  logic [BUS_WIDTH-1:0] quot_bus_c;
  logic                 unused_div;

  logic in_accept_c;
  logic final_beat_c;
  logic last_row_c;
  logic len_ok_c;

  assign in_accept_c  = in_valid && in_ready;
  assign last_row_c   = (row_cnt_q == ROW_W'(ROWS - 1));
  assign final_beat_c = last_row_c && (tok_cnt_q == n_q - LEN_W'(1));
  assign len_ok_c     = (sequence_length != '0) && (sequence_length <= LEN_W'(MAX_TOKENS));

  // Sign-extend each input lane to accumulator width.
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      lane_ext_c[l] = ACC_W'($signed(in_data[l*LANE_W +: LANE_W]));
    end
  end

  // Row-wise read-modify-write; token 0 overwrites so the array needs no clear.
  always_ff @(posedge clk) begin
    if (!rst && in_accept_c) begin
      for (int l = 0; l < int'(LANES); l++) begin
        acc_q[row_cnt_q][l] <= (tok_cnt_q == '0) ? lane_ext_c[l]
                                                 : acc_q[row_cnt_q][l] + lane_ext_c[l];
      end
    end
  end

  // One divider per lane, all started together on the current row.
  for (genvar l = 0; l < int'(LANES); l++) begin : g_div
    seq_divider #(
      .NUM_W (ACC_W),
      .DEN_W (LEN_W)
    ) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (div_start_q),
      .numer (acc_q[row_cnt_q][l]),
      .denom (n_q),
      .busy  (div_busy[l]),
      .done  (div_done[l]),
      .quot  (div_quot[l])
    );
  end

  // Means always fit a lane word; upper quotient bits are sign copies.
  always_comb begin
    quot_bus_c = '0;
    unused_div = ^div_busy;
    for (int l = 0; l < int'(LANES); l++) begin
      quot_bus_c[l*LANE_W +: LANE_W] = div_quot[l][LANE_W-1:0];
      unused_div = unused_div ^ (^div_quot[l][ACC_W-1:LANE_W]);
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      tok_cnt_q   <= '0;
      row_cnt_q   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      tok_cnt_q   <= tok_cnt_d;
      row_cnt_q   <= row_cnt_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      out_last    <= out_last_d;
      out_data    <= out_data_d;
      div_start_q <= div_start_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    tok_cnt_d   = tok_cnt_q;
    row_cnt_d   = row_cnt_q;
    busy_d      = busy;
    done_d      = 1'b0;
    err_d       = err;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    out_data_d  = out_data;
    div_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok_c) begin
            n_d        = sequence_length;
            tok_cnt_d  = '0;
            row_cnt_d  = '0;
            err_d      = 1'b0;
            busy_d     = 1'b1;
            in_ready_d = 1'b1;
            state_d    = ACCUM;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end

      ACCUM: begin
        if (in_accept_c) begin
          // Framing is purely by count; in_last only feeds the error flag.
          if (in_last != final_beat_c) begin
            err_d = 1'b1;
          end
          if (final_beat_c) begin
            in_ready_d  = 1'b0;
            row_cnt_d   = '0;
            tok_cnt_d   = '0;
            div_start_d = 1'b1;
            state_d     = DIV;
          end else if (last_row_c) begin
            row_cnt_d = '0;
            tok_cnt_d = tok_cnt_q + LEN_W'(1);
          end else begin
            row_cnt_d = row_cnt_q + ROW_W'(1);
          end
        end
      end

      DIV: begin
        if (&div_done) begin
          out_valid_d = 1'b1;
          out_data_d  = quot_bus_c;
          out_last_d  = last_row_c;
          state_d     = OUT;
        end
      end

      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!last_row_c) begin
            row_cnt_d   = row_cnt_q + ROW_W'(1);
            div_start_d = 1'b1;
            state_d     = DIV;
          end else begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mean_pool_stage.sv
// Scoreboard bench for mean_pool_stage: the driver fills token data, computes the
// expected means with plain integer arithmetic and queues the expected beats; a
// negedge monitor pops and compares every output handshake.
module tb_mean_pool_stage;

  localparam int LANES = 16;
  localparam int ROWS  = 24;
  localparam int DIM   = 384;
  localparam int MT    = 128;
  localparam int BW    = 512;
  localparam int LAT   = 41;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    sequence_length = '0;
  logic          busy, done, err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_data;
  logic          out_last;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int cyc = 0;
  int ref_cyc = 0;
  int bp_beat = -1;
  bit rand_ready = 0;
  int beat_idx = 0;
  int hold = 0;
  bit prev_valid = 0;
  logic [BW-1:0] held_data;
  logic          held_last;

  beat_t exp_q[$];
  logic [31:0] mem [MT][DIM];

  mean_pool_stage dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .sequence_length (sequence_length),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_last         (in_last),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic abort_run(input string why);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting on DUT", why);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench stopped");
  endtask

  // Output monitor: latency, backpressure stability, scoreboard compare.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
      hold = 0;
      beat_idx = 0;
    end else begin
      if (done) done_cnt++;
      if (out_valid) begin
        if (!prev_valid) chk("out_latency", 64'(cyc - ref_cyc), 64'(LAT));
        if (bp_beat == beat_idx && hold < 10) begin
          out_ready = 1'b0;
          if (hold == 0) begin
            held_data = out_data;
            held_last = out_last;
          end else begin
            checks++;
            if (out_data !== held_data || out_last !== held_last) begin
              failures++;
              $display("FAIL bp_stable: got last=%b data=%h expected last=%b data=%h",
                       out_last, out_data, held_last, held_data);
            end
          end
          hold++;
        end else if (rand_ready && $urandom_range(0, 3) == 0) begin
          out_ready = 1'b0;
        end else begin
          beat_t e;
          out_ready = 1'b1;
          hold = 0;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat: got data=%h last=%b expected no beat", out_data, out_last);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e.data || out_last !== e.last) begin
              failures++;
              $display("FAIL out_beat[%0d]: got last=%b data=%h expected last=%b data=%h",
                       beat_idx, out_last, out_data, e.last, e.data);
            end
            beat_idx = e.last ? 0 : beat_idx + 1;
          end
          chk("no_overlap_in_ready", 64'(in_ready), 64'(0));
          ref_cyc = cyc + 1;
        end
      end else begin
        out_ready = 1'b1;
      end
      prev_valid = out_valid;
    end
  end

  function automatic logic [31:0] gen_word(input int pat, input int t, input int d);
    case (pat)
      0:       return 32'(d) << 16;
      1:       return 32'(t + 1) << 16;
      2:       return (t < 2) ? 32'hFFFF_FFFF : 32'h0000_0001;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic send_beat(input logic [BW-1:0] d, input logic l);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready) begin
      @(negedge clk);
      k++;
      if (k > 100) abort_run("in_ready_wait");
    end
    @(negedge clk);
  endtask

  // last_mode: 0 normal, 1 extra in_last on beat 3, 2 in_last missing on final beat.
  task automatic run_seq(input int n, input int pat, input int last_mode,
                         input int abort_at, input logic exp_err);
    int dc;
    int beat;
    int k;
    logic [BW-1:0] bus;
    logic lb;
    longint s;
    for (int t = 0; t < n; t++)
      for (int d = 0; d < DIM; d++)
        mem[t][d] = gen_word(pat, t, d);
    if (abort_at < 0) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int l = 0; l < LANES; l++) begin
          s = 0;
          for (int t = 0; t < n; t++) s += longint'($signed(mem[t][r*LANES+l]));
          s = s / longint'(n);
          bus[l*32 +: 32] = 32'(s);
        end
        exp_q.push_back('{data: bus, last: (r == ROWS - 1)});
      end
    end
    dc = done_cnt;
    start = 1'b1;
    sequence_length = 8'(n);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
    beat = 0;
    for (int t = 0; t < n; t++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (beat == abort_at) begin
          in_valid = 1'b0;
          in_last  = 1'b0;
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk("abort_in_ready", 64'(in_ready), 64'(0));
          chk("abort_busy", 64'(busy), 64'(0));
          chk("abort_out_valid", 64'(out_valid), 64'(0));
          repeat (60) @(negedge clk);
          chk("abort_no_done", 64'(done_cnt - dc), 64'(0));
          return;
        end
        for (int l = 0; l < LANES; l++) bus[l*32 +: 32] = mem[t][r*LANES+l];
        lb = (t == n - 1) && (r == ROWS - 1);
        if (last_mode == 1 && beat == 3) lb = 1'b1;
        if (last_mode == 2 && lb) lb = 1'b0;
        send_beat(bus, lb);
        beat++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    ref_cyc  = cyc;
    // A start during the run must be ignored (length 0 would otherwise raise err).
    start = 1'b1;
    sequence_length = 8'd0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done_cnt == dc) begin
      @(negedge clk);
      k++;
      if (k > 5000) abort_run("done_wait");
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(done_cnt - dc), 64'(1));
    chk("err_flag", 64'(err), 64'(exp_err));
    chk("busy_idle", 64'(busy), 64'(0));
    chk("beats_left", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic bad_start(input int len);
    int dc = done_cnt;
    int k = 0;
    start = 1'b1;
    sequence_length = 8'(len);
    @(negedge clk);
    start = 1'b0;
    while (done_cnt == dc && k < 10) begin
      @(negedge clk);
      k++;
    end
    repeat (30) @(negedge clk);
    chk("badlen_done", 64'(done_cnt - dc), 64'(1));
    chk("badlen_err", 64'(err), 64'(1));
    chk("badlen_busy", 64'(busy), 64'(0));
    chk("badlen_in_ready", 64'(in_ready), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_data_or", 64'(|out_data), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run_seq(1, 0, 0, -1, 1'b0);
    run_seq(4, 1, 0, -1, 1'b0);
    run_seq(3, 2, 0, -1, 1'b0);
    run_seq(128, 3, 0, -1, 1'b0);
    run_seq(128, 4, 0, -1, 1'b0);
    bp_beat = 5;
    run_seq(2, 5, 0, -1, 1'b0);
    bp_beat = -1;
    bad_start(0);
    bad_start(129);
    run_seq(2, 5, 1, -1, 1'b1);
    run_seq(2, 5, 2, -1, 1'b1);
    run_seq(2, 5, 0, 5, 1'b0);
    run_seq(1, 0, 0, -1, 1'b0);
    rand_ready = 1;
    for (int i = 0; i < 3; i++) run_seq(int'($urandom_range(1, 6)), 5, 0, -1, 1'b0);
    rand_ready = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
